// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with a 2-entry skid buffer and flush bubble.
// Optional perf counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int CTRL_W = 7,
    parameter int DATA_W = 137
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              push;
    logic              pop;

    // Handshake flags come straight off the state register.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // Payloads are kept; only control is killed.
            state     <= EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state     <= ONE;
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state     <= FULL;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (pop && !push) begin
                        state     <= EMPTY;
                        main_ctrl <= '0;
                    end else if (push && pop) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state     <= ONE;
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_ctrl <= '0;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall;
    logic bubble;

    assign stall  = out_valid & ~out_ready;
    assign bubble = ~out_valid;

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios then random traffic.
// A queue of held entries models the stage; checks run on every falling edge.
module tb_pipe_stage_skid;

    localparam int CW = 7;
    localparam int DW = 137;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic          perf_clr = 1'b0;
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
    int unsigned   m_stall;
    int unsigned   m_bubble;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t q[$];
    bit   started  = 0;
    bit   zero     = 0;
    int   n;
    logic stalled;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
`ifdef PIPE_STAGE_PERF_EN
        .perf_clr  (perf_clr),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] r;
        for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom;
        return r[DW-1:0];
    endfunction

    // Monitor and reference model: compare, then advance model for next edge.
    always @(negedge clk) begin
        n = q.size();
        if (started) begin
            check("occupancy", occupancy, n);
            check("in_ready", in_ready, n < 2);
            check("out_valid", out_valid, n != 0);
            if (n != 0) begin
                check("out_ctrl", out_ctrl, q[0].c);
                check("out_data", out_data, q[0].d);
            end else begin
                check("out_ctrl_idle", out_ctrl, 0);
                if (zero) check("out_data_reset", out_data, 0);
            end
`ifdef PIPE_STAGE_PERF_EN
            check("stall_cnt", stall_cnt, m_stall);
            check("bubble_cnt", bubble_cnt, m_bubble);
`endif
        end
`ifdef PIPE_STAGE_PERF_EN
        if (rst || perf_clr) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (n != 0 && !out_ready) m_stall++;
            if (n == 0) m_bubble++;
        end
`endif
        if (rst) begin
            q.delete();
            started = 1;
            zero    = 1;
        end else if (started) begin
            if (n != 0 && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && n < 2) begin
                q.push_back('{c: in_ctrl, d: in_data});
                zero = 0;
            end
        end
    end

    task automatic step(input logic iv, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic ordy,
                        input logic fl, input logic r);
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0);
        // streaming at full rate
        for (int i = 0; i < 8; i++) step(1, 7'h55, DW'(i), 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // fill to two, then drain
        step(1, 7'h11, DW'(32'hA), 0, 0, 0);
        step(1, 7'h22, DW'(32'hB), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0);
        // flush while full with a same-cycle entry offered
        step(1, 7'h33, DW'(32'hC), 0, 0, 0);
        step(1, 7'h44, DW'(32'hD), 0, 0, 0);
        step(1, 7'h66, DW'(32'hE), 0, 1, 0);
        step(1, 7'h77, DW'(32'hF), 0, 0, 0);
        step(1, 7'h0F, DW'(32'h10), 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // reset plus flush mid-stream
        step(1, 7'h12, rand_data(), 1, 0, 0);
        step(1, 7'h13, rand_data(), 0, 0, 0);
        step(1, 7'h14, rand_data(), 0, 0, 0);
        step(1, 7'h15, rand_data(), 1, 1, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // stall window
        step(1, 7'h7F, rand_data(), 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0, 0);
`ifdef PIPE_STAGE_PERF_EN
        perf_clr = 1'b1;
`endif
        step(0, 0, 0, 0, 0, 0);
`ifdef PIPE_STAGE_PERF_EN
        perf_clr = 1'b0;
`endif
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // random traffic honouring the hold-while-stalled rule
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            stalled = in_valid && !in_ready && !flush && !rst;
            @(posedge clk);
            #1;
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef PIPE_STAGE_PERF_EN
            perf_clr  = ($urandom_range(0, 49) == 0);
`endif
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_ctrl  = 7'($urandom);
                in_data  = rand_data();
            end
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
